// File: rtl/spi_seq_pkg.sv
// Shared types and widths for the SPI burst sequencer.
// Imported by the FIFO, the interface and the top.
package spi_seq_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    STORE,
    GAP
  } seq_state_t;

endpackage

// File: rtl/spi_burst_sequencer_if.sv
// Command, TX and RX streams between upstream logic and the sequencer.
// master drives commands/TX bytes and consumes RX bytes.
interface spi_burst_sequencer_if;
  import spi_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SPI_LEN_W-1:0]  cmd_len;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;

  modport master (
    output cmd_valid, cmd_len, tx_valid, tx_data, rx_ready,
    input  cmd_ready, tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  cmd_valid, cmd_len, tx_valid, tx_data, rx_ready,
    output cmd_ready, tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_seq_fifo.sv
// Synchronous valid/ready FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_seq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push}
                     - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer: feeds the byte engine from a TX FIFO,
// collects replies in an RX FIFO, frames the burst with cs_n.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_burst_sequencer_if.slave  bus,
  output logic                  byte_start,
  output logic [SPI_BYTE_W-1:0] byte_tx,
  input  logic                  byte_done,
  input  logic [SPI_BYTE_W-1:0] byte_rx,
  output logic                  cs_n,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  seq_state_t state;
  seq_state_t state_nx;

  logic [SPI_LEN_W-1:0]  remaining;
  logic [15:0]           gap_cnt;
  logic                  tx_vld;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic [CW-1:0]         tx_cnt;
  logic                  rx_rdy;
  logic [CW-1:0]         rx_cnt;
  logic                  accept;
  logic                  go;
  logic                  tx_pop;
  logic                  rx_push;

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.tx_valid),
    .in_ready  (bus.tx_ready),
    .in_data   (bus.tx_data),
    .out_valid (tx_vld),
    .out_ready (tx_pop),
    .out_data  (tx_head),
    .count     (tx_cnt)
  );

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rx_push),
    .in_ready  (rx_rdy),
    .in_data   (byte_rx),
    .out_valid (bus.rx_valid),
    .out_ready (bus.rx_ready),
    .out_data  (bus.rx_data),
    .count     (rx_cnt)
  );

  // Launch only when the reply already has a slot reserved.
  assign accept = (state == IDLE) && bus.cmd_valid
                  && (bus.cmd_len != '0);
  assign go     = (tx_cnt != '0) && (rx_cnt < FULL_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   if (go) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (byte_done) state_nx = STORE;
      STORE:   state_nx = (remaining == '0) ? GAP : SETUP;
      GAP:     if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    busy          = (state != IDLE);
    byte_start    = (state == START);
    cs_n          = !(state inside {SETUP, START, WAIT, STORE});
    tx_pop        = (state == SETUP) && go && tx_vld;
    rx_push       = (state == WAIT) && byte_done && rx_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      byte_tx   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (accept)       remaining <= bus.cmd_len;
      else if (rx_push) remaining <= remaining - 1'b1;
      if (tx_pop) byte_tx <= tx_head;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule
